// File: rtl/memory_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one memory handshake (MFA/MOC).
// Also performs alignment checks, applies a wait timeout, and zero-extends narrow loads.
module memory_port_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_rw,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic        MFA,
    output logic        mem_rw,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        MOC
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic [1:0]  ls_streak;
    logic        owner_ls;
    logic [31:0] rdata_raw;

    logic        pulse_busy, if_act, ls_act, grant_any, pick_ls;
    logic        ls_bad, if_bad, grant_bad, timeout_hit;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lsb);
        logic [31:0] r;
        case (size)
            2'b00:   r = {24'h0, word[{lsb, 3'b000} +: 8]};
            2'b01:   r = {16'h0, word[{lsb[1], 4'b0000} +: 16]};
            default: r = word;
        endcase
        return r;
    endfunction

    // While a done pulse is showing, its requester still holds req; granting
    // nothing in that cycle keeps the finished request from being served twice.
    assign pulse_busy  = if_done | ls_done;
    assign if_act      = if_req & ~pulse_busy;
    assign ls_act      = ls_req & ~pulse_busy;
    assign grant_any   = if_act | ls_act;
    assign pick_ls     = ls_act & (~if_act | (ls_streak != 2'd2));
    assign ls_bad      = (ls_size == 2'b11)
                       | ((ls_size == 2'b01) & ls_addr[0])
                       | ((ls_size == 2'b10) & (ls_addr[1:0] != 2'b00));
    assign if_bad      = (if_addr[1:0] != 2'b00);
    assign grant_bad   = pick_ls ? ls_bad : if_bad;
    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant_any) state_nxt = grant_bad ? ERR : WAIT;
            WAIT:      if (MOC) state_nxt = DONE;
                       else if (timeout_hit) state_nxt = ERR;
            DONE, ERR: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
            MFA       <= 1'b0;
            mem_rw    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            ls_streak <= '0;
            owner_ls  <= 1'b0;
            rdata_raw <= '0;
        end else begin
            if_done <= 1'b0;
            if_err  <= 1'b0;
            ls_done <= 1'b0;
            ls_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_ls  <= pick_ls;
                        MFA       <= ~grant_bad;
                        wait_cnt  <= '0;
                        mem_rw    <= pick_ls ? ls_rw    : 1'b1;
                        mem_size  <= pick_ls ? ls_size  : 2'b10;
                        mem_addr  <= pick_ls ? ls_addr  : if_addr;
                        mem_wdata <= pick_ls ? ls_wdata : 32'h0;
                    end
                    if (grant_any && !pick_ls)
                        ls_streak <= '0;
                    else if (grant_any && if_req)
                        ls_streak <= (ls_streak == 2'd2) ? 2'd2 : ls_streak + 2'd1;
                    else if (!if_req)
                        ls_streak <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (MOC) begin
                        rdata_raw <= mem_rdata;
                        MFA       <= 1'b0;
                    end else if (timeout_hit) begin
                        MFA <= 1'b0;
                    end
                end
                DONE: begin
                    if (owner_ls) begin
                        ls_done  <= 1'b1;
                        ls_rdata <= mem_rw ? load_extract(rdata_raw, mem_size, mem_addr[1:0]) : '0;
                    end else begin
                        if_done  <= 1'b1;
                        if_rdata <= rdata_raw;
                    end
                end
                ERR: begin
                    if (owner_ls) begin
                        ls_done  <= 1'b1;
                        ls_err   <= 1'b1;
                        ls_rdata <= '0;
                    end else begin
                        if_done  <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= '0;
                    end
                end
                default: MFA <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios with literal expectations,
// then random requester/memory traffic checked every cycle against a transaction-level model.
module tb_memory_port_arbiter;
    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done, if_err;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_rw = 1'b0;
    logic [1:0]  ls_size = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done, ls_err;
    logic [31:0] ls_rdata;
    logic        MFA, mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        MOC = 1'b0;

    memory_port_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .CLR(CLR),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_rw(ls_rw), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .MFA(MFA), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .MOC(MOC)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    bit moc_stop = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm, input int cycles);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no completion within %0d cycles at %0t", nm, cycles, $time);
    endtask

    // Transaction-level reference: one outstanding access, its grant edge,
    // the edge at which its outcome became known, and the report one edge later.
    logic        e_mfa, e_if_done, e_if_err, e_ls_done, e_ls_err;
    logic [31:0] e_if_rdata, e_ls_rdata;
    logic        e_rw;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata, m_raw, m_res;
    bit          m_act, m_ended, m_blocked, m_ls, m_err;
    int          m_streak, m_edge, m_grant;

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic [31:0] a);
        int sh;
        case (size)
            2'b00: begin
                sh = 8 * int'(a % 4);
                return (w >> sh) & 32'h0000_00FF;
            end
            2'b01: begin
                sh = ((a % 4) >= 2) ? 16 : 0;
                return (w >> sh) & 32'h0000_FFFF;
            end
            default: return w;
        endcase
    endfunction

    always @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            e_mfa = 0; e_if_done = 0; e_if_err = 0; e_ls_done = 0; e_ls_err = 0;
            e_if_rdata = 0; e_ls_rdata = 0;
            e_rw = 0; e_size = 0; e_addr = 0; e_wdata = 0;
            m_act = 0; m_ended = 0; m_blocked = 0; m_streak = 0;
        end else begin
            m_edge++;
            e_if_done = 0; e_if_err = 0; e_ls_done = 0; e_ls_err = 0;
            if (m_act && m_ended) begin
                m_res = (m_err || !e_rw) ? 32'h0 : ref_load(m_raw, e_size, e_addr);
                if (m_ls) begin
                    e_ls_done = 1; e_ls_err = m_err; e_ls_rdata = m_res;
                end else begin
                    e_if_done = 1; e_if_err = m_err; e_if_rdata = m_res;
                end
                m_act = 0;
                m_blocked = 1;
            end else if (m_act) begin
                if (MOC) begin
                    m_raw = mem_rdata; m_err = 0; m_ended = 1; e_mfa = 0;
                end else if (m_edge - m_grant == TO) begin
                    m_err = 1; m_ended = 1; e_mfa = 0;
                end
            end else if (m_blocked) begin
                m_blocked = 0;
                if (!if_req) m_streak = 0;
            end else if (if_req || ls_req) begin
                m_ls = ls_req && !(if_req && m_streak == 2);
                if (!m_ls)       m_streak = 0;
                else if (if_req) m_streak = (m_streak >= 2) ? 2 : m_streak + 1;
                else             m_streak = 0;
                m_grant = m_edge;
                m_act = 1;
                if (m_ls) begin
                    e_rw = ls_rw; e_size = ls_size; e_addr = ls_addr; e_wdata = ls_wdata;
                    m_err = (ls_size == 2'd3) || (ls_size == 2'd1 && (ls_addr % 2) != 0)
                         || (ls_size == 2'd2 && (ls_addr % 4) != 0);
                end else begin
                    e_rw = 1; e_size = 2'd2; e_addr = if_addr; e_wdata = 0;
                    m_err = (if_addr % 4) != 0;
                end
                m_ended = m_err;
                e_mfa = !m_err;
            end else begin
                m_streak = 0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("MFA", 32'(MFA), 32'(e_mfa));
            chk("if_done", 32'(if_done), 32'(e_if_done));
            chk("if_err", 32'(if_err), 32'(e_if_err));
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("ls_done", 32'(ls_done), 32'(e_ls_done));
            chk("ls_err", 32'(ls_err), 32'(e_ls_err));
            chk("ls_rdata", ls_rdata, e_ls_rdata);
            if (e_mfa) begin
                chk("mem_rw", 32'(mem_rw), 32'(e_rw));
                chk("mem_size", 32'(mem_size), 32'(e_size));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    task automatic drive_if(input int n);
        int guard;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            if_addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) if_addr[1:0] = 2'($urandom_range(1, 3));
            if_req = 1'b1;
            guard = 0;
            do begin
                @(negedge CLK);
                guard++;
            end while (!if_done && guard < 200);
            if (!if_done) bound_fail("if_handshake", guard);
            else @(negedge CLK);
            if_req = 1'b0;
        end
    endtask

    task automatic drive_ls(input int n);
        int guard;
        int pick;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            pick = $urandom_range(0, 9);
            ls_size = (pick < 3) ? 2'b00 : (pick < 6) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
            ls_addr = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                if (ls_size == 2'b01) ls_addr[0] = 1'b0;
                if (ls_size == 2'b10) ls_addr[1:0] = 2'b00;
            end
            ls_rw = 1'($urandom_range(0, 1));
            ls_wdata = $urandom;
            ls_req = 1'b1;
            guard = 0;
            do begin
                @(negedge CLK);
                guard++;
            end while (!ls_done && guard < 200);
            if (!ls_done) bound_fail("ls_handshake", guard);
            else @(negedge CLK);
            ls_req = 1'b0;
        end
    endtask

    task automatic moc_drive();
        int cyc;
        int pct;
        cyc = 0;
        while (!moc_stop) begin
            @(negedge CLK);
            cyc++;
            case ((cyc / 150) % 3)
                0:       pct = 50;
                1:       pct = 15;
                default: pct = 0;
            endcase
            MOC = ($urandom_range(0, 99) < pct);
            mem_rdata = $urandom;
        end
        MOC = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] grants[$];
        logic [31:0] exp_ord[6];
        logic        prev_mfa;
        int          cnt;
        int          guard;

        repeat (3) @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        chk_on = 1'b1;

        chk("rst_MFA", 32'(MFA), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_ls_done", 32'(ls_done), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_size", 32'(mem_size), 32'h0);

        // fetch read at minimum latency
        if_addr = 32'h100; if_req = 1'b1;
        @(negedge CLK);
        chk("fetch_MFA_rise", 32'(MFA), 32'h1);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_mem_size", 32'(mem_size), 32'h2);
        MOC = 1'b1; mem_rdata = 32'hE3A0_1005;
        @(negedge CLK);
        chk("fetch_MFA_fall", 32'(MFA), 32'h0);
        chk("fetch_done_early", 32'(if_done), 32'h0);
        MOC = 1'b0; mem_rdata = 32'h0;
        @(negedge CLK);
        chk("fetch_done", 32'(if_done), 32'h1);
        chk("fetch_err", 32'(if_err), 32'h0);
        chk("fetch_rdata", if_rdata, 32'hE3A0_1005);
        @(negedge CLK);
        if_req = 1'b0;
        chk("fetch_done_once", 32'(if_done), 32'h0);
        chk("fetch_rdata_hold", if_rdata, 32'hE3A0_1005);

        // byte load from the top byte lane
        ls_rw = 1'b1; ls_size = 2'b00; ls_addr = 32'h203; ls_wdata = 32'h0; ls_req = 1'b1;
        @(negedge CLK);
        chk("byte_MFA", 32'(MFA), 32'h1);
        chk("byte_mem_size", 32'(mem_size), 32'h0);
        chk("byte_mem_addr", mem_addr, 32'h203);
        MOC = 1'b1; mem_rdata = 32'hAABB_CCDD;
        @(negedge CLK);
        MOC = 1'b0;
        @(negedge CLK);
        chk("byte_done", 32'(ls_done), 32'h1);
        chk("byte_rdata", ls_rdata, 32'h0000_00AA);
        @(negedge CLK);
        ls_req = 1'b0;

        // misaligned word store
        ls_rw = 1'b0; ls_size = 2'b10; ls_addr = 32'h202; ls_wdata = 32'hDEAD_BEEF; ls_req = 1'b1;
        @(negedge CLK);
        chk("mis_MFA", 32'(MFA), 32'h0);
        chk("mis_done_early", 32'(ls_done), 32'h0);
        @(negedge CLK);
        chk("mis_done", 32'(ls_done), 32'h1);
        chk("mis_err", 32'(ls_err), 32'h1);
        chk("mis_MFA_low", 32'(MFA), 32'h0);
        @(negedge CLK);
        ls_req = 1'b0;

        // timeout with MOC never asserted
        ls_rw = 1'b1; ls_size = 2'b10; ls_addr = 32'h300; ls_req = 1'b1; MOC = 1'b0;
        cnt = 0; guard = 0;
        do begin
            @(negedge CLK);
            if (MFA) cnt++;
            guard++;
        end while (!ls_done && guard < 60);
        if (!ls_done) bound_fail("tmo_wait", guard);
        chk("tmo_mfa_cycles", 32'(cnt), 32'd15);
        chk("tmo_err", 32'(ls_err), 32'h1);
        chk("tmo_rdata", ls_rdata, 32'h0);
        @(negedge CLK);
        ls_req = 1'b0;

        // MOC arriving in the last allowed wait cycle
        ls_addr = 32'h304; ls_req = 1'b1; mem_rdata = 32'h1234_5678;
        cnt = 0; guard = 0;
        do begin
            @(negedge CLK);
            if (MFA) cnt++;
            MOC = MFA && (cnt == TO);
            guard++;
        end while (!ls_done && guard < 60);
        if (!ls_done) bound_fail("late_moc_wait", guard);
        chk("late_moc_cycles", 32'(cnt), 32'd15);
        chk("late_moc_err", 32'(ls_err), 32'h0);
        chk("late_moc_rdata", ls_rdata, 32'h1234_5678);
        @(negedge CLK);
        ls_req = 1'b0; MOC = 1'b0;

        // reset in the middle of a wait
        if_addr = 32'h500; if_req = 1'b1;
        @(negedge CLK);
        chk("rstw_MFA_rise", 32'(MFA), 32'h1);
        #2 CLR = 1'b0;
        #1 chk("rstw_MFA_async", 32'(MFA), 32'h0);
        if_req = 1'b0;
        @(negedge CLK);
        chk("rstw_no_done", 32'(if_done), 32'h0);
        chk("rstw_if_rdata", if_rdata, 32'h0);
        chk("rstw_ls_rdata", ls_rdata, 32'h0);
        #2 CLR = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("rstw_quiet", 32'(if_done | MFA), 32'h0);
        end

        // contention: both requesters held, memory answers immediately
        if_addr = 32'h400; ls_addr = 32'h800; ls_rw = 1'b1; ls_size = 2'b10;
        MOC = 1'b1; if_req = 1'b1; ls_req = 1'b1;
        prev_mfa = 1'b0; guard = 0;
        while (grants.size() < 6 && guard < 80) begin
            @(negedge CLK);
            guard++;
            if (MFA && !prev_mfa) grants.push_back(mem_addr);
            prev_mfa = MFA;
        end
        ls_req = 1'b0;
        exp_ord = '{32'h800, 32'h800, 32'h400, 32'h800, 32'h800, 32'h400};
        for (int i = 0; i < 6; i++)
            chk($sformatf("grant_order_%0d", i), (i < grants.size()) ? grants[i] : 32'hFFFF_FFFF, exp_ord[i]);
        guard = 0;
        while (!if_done && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (!if_done) bound_fail("contention_drain", guard);
        @(negedge CLK);
        if_req = 1'b0; MOC = 1'b0;
        repeat (2) @(negedge CLK);

        // randomized traffic
        fork
            begin
                fork
                    drive_if(120);
                    drive_ls(120);
                join
                moc_stop = 1'b1;
            end
            moc_drive();
        join
        repeat (4) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
